conware_grid: RTL and testbench

- Parametrised multi-row Game-of-Life engine; successor to the single-row stream pipeline.
- Accepts a WIDTH x HEIGHT frame as an AXI-Stream of pixels and converts each pixel to a cell state.
- Advances the grid a programmable number of generations (one generation per clock) and streams the result out as pixels.
- Sits between the input VDMA/DMA stream and the output stream in the conware datapath.

---
 rtl/conware_pkg.sv | 18 +
 rtl/conware_cell_next.sv | 20 ++
 rtl/conware_grid.sv | 206 ++++++++++++++++++++
 tb/tb_conware_grid.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// Shared types, default colours and the B3/S23 rule for the conware grid engine.
package conware_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        DISCARD = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_e;

    localparam logic [31:0] DEF_ALIVE_COLOR = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_DEAD_COLOR  = 32'h0000_0000;

    function automatic logic next_state(input logic alive, input logic [3:0] count);
        return (count == 4'd3) || (alive && (count == 4'd2));
    endfunction

endpackage

// File: rtl/conware_cell_next.sv
// One Game-of-Life cell: counts eight neighbour bits and applies the B3/S23 rule.
module conware_cell_next
    import conware_pkg::*;
(
    input  logic [7:0] nbr_i,
    input  logic       self_i,
    output logic       next_o
);

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            count = count + {3'b000, nbr_i[i]};
        end
        next_o = next_state(self_i, count);
    end

endmodule

// File: rtl/conware_grid.sv
// WIDTH x HEIGHT Game-of-Life engine: load a frame from AXI-Stream, run N generations, stream it out.
// Optional macro CONWARE_EARLY_EXIT_EN: stop computing once the grid stops changing and add the 'stable' port.
module conware_grid
    import conware_pkg::*;
#(
    parameter int                DWIDTH      = 32,
    parameter int                WIDTH       = 8,
    parameter int                HEIGHT      = 4,
    parameter int                GEN_W       = 8,
    parameter logic [DWIDTH-1:0] ALIVE_COLOR = DWIDTH'(DEF_ALIVE_COLOR),
    parameter logic [DWIDTH-1:0] DEAD_COLOR  = DWIDTH'(DEF_DEAD_COLOR)
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                S_AXIS_TVALID,
    output logic                S_AXIS_TREADY,
    input  logic [DWIDTH-1:0]   S_AXIS_TDATA,
    input  logic                S_AXIS_TLAST,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic [DWIDTH-1:0]   M_AXIS_TDATA,
    output logic                M_AXIS_TLAST,
    output logic [DWIDTH/8-1:0] M_AXIS_TKEEP,
    output logic [DWIDTH/8-1:0] M_AXIS_TSTRB,
    input  logic [GEN_W-1:0]    num_gens,
    input  logic                wrap_mode,
    output logic                busy,
    output logic                err_len,
    output logic [31:0]         frames_done
`ifdef CONWARE_EARLY_EXIT_EN
    ,
    output logic                stable
`endif
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int IDX_W = $clog2(CELLS);

    state_e             state_q, state_d;
    logic [CELLS-1:0]   cells_q, cells_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic [GEN_W-1:0]   gens_q, gens_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic [31:0]        frames_q, frames_d;
`ifdef CONWARE_EARLY_EXIT_EN
    logic               stable_q, stable_d;
`endif

    logic [CELLS-1:0]   next_grid;
    logic [CELLS-1:0]   keep_mask;
    logic [GEN_W-1:0]   gens_eff;
    logic               in_beat;
    logic               out_beat;
    logic               pix_alive;
    logic               last_cell;

    // Neighbour selection: in-range neighbours are wired directly, out-of-range ones
    // resolve to their toroidal partner gated by the latched wrap mode.
    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [7:0] nbr;
            for (genvar k = 0; k < 9; k++) begin : g_nbr
                if (k != 4) begin : g_use
                    localparam int RR  = r + (k / 3) - 1;
                    localparam int CC  = c + (k % 3) - 1;
                    localparam bit INR = (RR >= 0) && (RR < HEIGHT) && (CC >= 0) && (CC < WIDTH);
                    localparam int IDX = ((RR + HEIGHT) % HEIGHT) * WIDTH + ((CC + WIDTH) % WIDTH);
                    localparam int POS = (k < 4) ? k : k - 1;
                    if (INR) begin : g_in
                        assign nbr[POS] = cells_q[IDX];
                    end else begin : g_edge
                        assign nbr[POS] = wrap_q & cells_q[IDX];
                    end
                end
            end
            conware_cell_next u_cell (
                .nbr_i  (nbr),
                .self_i (cells_q[r*WIDTH + c]),
                .next_o (next_grid[r*WIDTH + c])
            );
        end
    end

    assign S_AXIS_TREADY = (state_q == LOAD) || (state_q == DISCARD);
    assign in_beat       = S_AXIS_TVALID && S_AXIS_TREADY;
    assign out_beat      = M_AXIS_TVALID && M_AXIS_TREADY;
    assign pix_alive     = (S_AXIS_TDATA == ALIVE_COLOR);
    assign last_cell     = (cnt_q == IDX_W'(CELLS - 1));
    assign gens_eff      = (cnt_q == '0) ? num_gens : gens_q;
    assign keep_mask     = {CELLS{1'b1}} >> (IDX_W'(CELLS - 1) - cnt_q);

    always_comb begin
        state_d  = state_q;
        cells_d  = cells_q;
        cnt_d    = cnt_q;
        gen_d    = gen_q;
        gens_d   = gens_q;
        wrap_d   = wrap_q;
        err_d    = err_q;
        frames_d = frames_q;
`ifdef CONWARE_EARLY_EXIT_EN
        stable_d = stable_q;
`endif
        unique case (state_q)
            LOAD: begin
                if (in_beat) begin
                    cells_d[cnt_q] = pix_alive;
                    if (cnt_q == '0) begin
                        gens_d = num_gens;
                        wrap_d = wrap_mode;
                    end
                    if (S_AXIS_TLAST) begin
                        // A short frame leaves stale cells above cnt; the mask clears them.
                        err_d   = err_q | ~last_cell;
                        cells_d = cells_d & keep_mask;
                        cnt_d   = '0;
                        state_d = (gens_eff == '0) ? OUTPUT : COMPUTE;
                    end else if (last_cell) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = DISCARD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (in_beat && S_AXIS_TLAST) begin
                    state_d = (gens_q == '0) ? OUTPUT : COMPUTE;
                end
            end
            COMPUTE: begin
                cells_d = next_grid;
                gen_d   = gen_q + 1'b1;
                if (gen_d == gens_q) begin
                    state_d = OUTPUT;
                end
`ifdef CONWARE_EARLY_EXIT_EN
                if (next_grid == cells_q) begin
                    state_d  = OUTPUT;
                    stable_d = 1'b1;
                end
`endif
            end
            OUTPUT: begin
                if (out_beat) begin
                    if (last_cell) begin
                        cnt_d    = '0;
                        gen_d    = '0;
                        frames_d = frames_q + 32'd1;
                        state_d  = LOAD;
`ifdef CONWARE_EARLY_EXIT_EN
                        stable_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= LOAD;
            cells_q  <= '0;
            cnt_q    <= '0;
            gen_q    <= '0;
            gens_q   <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            frames_q <= '0;
`ifdef CONWARE_EARLY_EXIT_EN
            stable_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cells_q  <= cells_d;
            cnt_q    <= cnt_d;
            gen_q    <= gen_d;
            gens_q   <= gens_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            frames_q <= frames_d;
`ifdef CONWARE_EARLY_EXIT_EN
            stable_q <= stable_d;
`endif
        end
    end

    assign M_AXIS_TVALID = (state_q == OUTPUT);
    assign M_AXIS_TDATA  = ((state_q == OUTPUT) && cells_q[cnt_q]) ? ALIVE_COLOR : DEAD_COLOR;
    assign M_AXIS_TLAST  = (state_q == OUTPUT) && last_cell;
    assign M_AXIS_TKEEP  = '1;
    assign M_AXIS_TSTRB  = '1;
    assign busy          = !((state_q == LOAD) && (cnt_q == '0));
    assign err_len       = err_q;
    assign frames_done   = frames_q;
`ifdef CONWARE_EARLY_EXIT_EN
    assign stable        = stable_q;
`endif

endmodule

// File: tb/tb_conware_grid.sv
// Self-checking bench for conware_grid (4x4 grid) against a behavioural Life model.
`timescale 1ns/1ps
module tb_conware_grid;

    localparam logic [31:0] ALIVE = 32'hFFFF_FFFF;
    localparam logic [31:0] DEAD  = 32'h0000_0000;

    logic        clk, rst_n;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep, m_tstrb;
    logic [7:0]  num_gens;
    logic        wrap_mode, busy, err_len;
    logic [31:0] frames_done;
`ifdef CONWARE_EARLY_EXIT_EN
    logic        stable;
`endif

    conware_grid #(.DWIDTH(32), .WIDTH(4), .HEIGHT(4), .GEN_W(8)) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata), .S_AXIS_TLAST(s_tlast),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TSTRB(m_tstrb),
        .num_gens(num_gens), .wrap_mode(wrap_mode), .busy(busy), .err_len(err_len),
`ifdef CONWARE_EARLY_EXIT_EN
        .stable(stable),
`endif
        .frames_done(frames_done)
    );

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    int          n_vec = 0, n_mis = 0;
    logic [15:0] exp_grid;
    longint      exp_lat, t_last;
    bit          exp_stable, exp_pending = 0, first_seen = 0, loading = 0, err_exp = 0;
    int          ocnt = 0, beats_acc = 0, frames_seen = 0;
    logic [31:0] frames_exp = 0;
    int          rmode = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain 4x4 Life step: count the eight neighbours by coordinates.
    function automatic logic [15:0] life_step(input logic [15:0] g, input bit wrap);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin rr = (rr + 4) % 4; cc = (cc + 4) % 4; end
                        else if (rr < 0 || rr > 3 || cc < 0 || cc > 3) continue;
                        cnt += int'(g[rr*4 + cc]);
                    end
                end
                n[r*4 + c] = (cnt == 3) || (g[r*4 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] dead_pix();
        logic [31:0] v = $urandom;
        if (v == ALIVE) v = 32'hFFFF_FFFE;
        return v[0] ? DEAD : v;
    endfunction

    // Output ready pattern generator.
    bit pat4 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    initial begin
        int pk = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: m_tready = 1'b1;
                1: begin m_tready = pat4[pk]; pk = (pk + 1) % 4; end
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process.
    always @(negedge clk) begin
        if (rst_n) begin
            check("tkeep", m_tkeep, 4'hF);
            check("tstrb", m_tstrb, 4'hF);
            check("frames_done", frames_done, frames_exp);
            check("err_len", err_len, err_exp);
            if (loading) begin
                check("s_tready_load", s_tready, 1);
                check("busy_load", busy, beats_acc > 0);
            end
            if (m_tvalid) begin
                if (!exp_pending) check("tvalid_spurious", m_tvalid, 0);
                else begin
                    if (!first_seen) begin
                        check("latency", $time - t_last, exp_lat);
                        first_seen = 1;
`ifdef CONWARE_EARLY_EXIT_EN
                        check("stable", stable, exp_stable);
`endif
                    end
                    if (prev_stall) begin
                        check("hold_tdata", m_tdata, prev_data);
                        check("hold_tlast", m_tlast, prev_last);
                    end
                    check("tdata", m_tdata, exp_grid[ocnt] ? ALIVE : DEAD);
                    check("tlast", m_tlast, ocnt == 15);
                    check("s_tready_out", s_tready, 0);
                    check("busy_out", busy, 1);
                    if (m_tready) begin
                        ocnt++;
                        if (ocnt == 16) begin
                            ocnt = 0; exp_pending = 0; first_seen = 0;
                            frames_exp++; frames_seen++;
                        end
                    end
                end
            end else if (exp_pending && first_seen) begin
                check("tvalid_dropped", m_tvalid, 1);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic send_frame(input logic [15:0] pat, input int nbeats, input int gens, input bit wrap);
        logic [15:0] g, nx;
        int geff = 0, err_beat;
        bit stab = 0;
        g = '0;
        for (int b = 0; b < 16; b++) if (b < nbeats) g[b] = pat[b];
        for (int k = 1; k <= gens; k++) begin
            nx = life_step(g, wrap);
            geff = k;
`ifdef CONWARE_EARLY_EXIT_EN
            if (nx == g) begin stab = 1; break; end
`endif
            g = nx;
        end
        exp_grid = g; exp_lat = 10 * geff + 5; exp_stable = stab;
        err_beat = (nbeats < 16) ? nbeats - 1 : ((nbeats > 16) ? 15 : -1);
        beats_acc = 0;
        loading = 1;
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) begin s_tvalid = 0; @(posedge clk); #1; end
            s_tvalid = 1;
            s_tdata  = (b < 16 && pat[b]) ? ALIVE : dead_pix();
            s_tlast  = (b == nbeats - 1);
            num_gens = (b == 0) ? 8'(gens) : 8'($urandom);
            wrap_mode = (b == 0) ? wrap : 1'($urandom);
            @(posedge clk);
            beats_acc++;
            if (b == err_beat) err_exp = 1;
            if (b == nbeats - 1) begin t_last = $time; exp_pending = 1; loading = 0; end
            #1;
        end
        s_tvalid = 0; s_tlast = 0;
    endtask

    task automatic run_frame(input logic [15:0] pat, input int nbeats, input int gens, input bit wrap);
        int target = frames_seen + 1;
        send_frame(pat, nbeats, gens, wrap);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frames_seen == target) break;
        end
        if (frames_seen != target) begin
            n_vec++; n_mis++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", frames_seen, target);
        end
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("s_tready_idle", s_tready, 1);
`ifdef CONWARE_EARLY_EXIT_EN
        check("stable_idle", stable, 0);
`endif
    endtask

    task automatic check_reset_vals();
        check("rst_s_tready", s_tready, 1);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, DEAD);
        check("rst_busy", busy, 0);
        check("rst_err", err_len, 0);
        check("rst_frames", frames_done, 0);
`ifdef CONWARE_EARLY_EXIT_EN
        check("rst_stable", stable, 0);
`endif
    endtask

    initial begin
        rst_n = 0; s_tvalid = 0; s_tlast = 0; s_tdata = '0; num_gens = '0; wrap_mode = 0;
        #23 check_reset_vals();
        #4 rst_n = 1;
        @(posedge clk); #1;

        check("model_blinker1", life_step(16'h00E0, 0), 16'h0444);
        check("model_blinker2", life_step(life_step(16'h00E0, 0), 0), 16'h00E0);
        check("model_block", life_step(16'h0660, 0), 16'h0660);

        run_frame(16'h00E0, 16, 1, 0);
        run_frame(16'h00E0, 16, 2, 0);
        check("frames_after_blinker", frames_done, 2);
        run_frame(16'h0742, 16, 16, 1);
        run_frame(16'h0742, 16, 16, 0);
        run_frame(16'hFFFF, 16, 0, 0);
        run_frame(16'hFFFF, 10, 0, 0);
        run_frame(16'($urandom), 20, 3, 1);
        rmode = 1;
        run_frame(16'($urandom), 16, 2, 1);
        rmode = 0;
        run_frame(16'h0660, 16, 200, 0);

        // Reset in the middle of a load.
        loading = 1; beats_acc = 0;
        for (int b = 0; b < 5; b++) begin
            s_tvalid = 1; s_tdata = ALIVE; s_tlast = 0; num_gens = 8'd3;
            @(posedge clk); beats_acc++; #1;
        end
        s_tvalid = 0; loading = 0;
        #2 rst_n = 0;
        #1 frames_exp = 0; err_exp = 0;
        check_reset_vals();
        #3 rst_n = 1;
        @(posedge clk); #1;

        rmode = 2;
        for (int f = 0; f < 14; f++) begin
            int nb = 16;
            case ($urandom_range(0, 5))
                0: nb = $urandom_range(1, 15);
                1: nb = $urandom_range(17, 22);
                default: nb = 16;
            endcase
            run_frame(16'($urandom), nb, $urandom_range(0, 20), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
